// File: rtl/bin_to_bcd_converter_pkg.sv
// bin_to_bcd_converter_pkg: shared state type and constants for the double-dabble converter
package bin_to_bcd_converter_pkg;
    localparam int IN_WIDTH_DEF = 16;
    localparam int DIGITS_DEF = 4;
    localparam int BCD_WIDTH = 4 * DIGITS_DEF;
    localparam int MAX_DEC = 10 ** DIGITS_DEF - 1;
    localparam int CNT_WIDTH = $clog2(IN_WIDTH_DEF + 1);
    localparam logic [3:0] ERR_NIBBLE = 4'hE;
    typedef enum logic {IDLE, SHIFT} state_e;
endpackage

// File: rtl/bin_to_bcd_converter_bcd_digit_adjust.sv
// bcd_digit_adjust: add 3 to a BCD digit of 5 or more before the next shift
module bcd_digit_adjust (
    input  logic [3:0] d_i,
    output logic [3:0] q_o
);
    assign q_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

// File: rtl/bin_to_bcd_converter.sv
// bin_to_bcd_converter: sequential double-dabble, one shift per clock, output held between conversions
module bin_to_bcd_converter
    import bin_to_bcd_converter_pkg::*;
#(
    parameter int IN_WIDTH = IN_WIDTH_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [IN_WIDTH-1:0]   bin,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(IN_WIDTH + 1);
    localparam logic [63:0] MAXV = 64'(10 ** DIGITS - 1);
    state_e state_q, state_d;
    logic [IN_WIDTH-1:0] sh_q, sh_d;
    logic [BW-1:0] scr_q, scr_d, adj;
    logic [CW-1:0] cnt_q, cnt_d;
    logic pend_q, pend_d, done_q, done_d, ovf_q, ovf_d;
    logic [BW-1:0] bcd_q, bcd_d;
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (.d_i(scr_q[4*g +: 4]), .q_o(adj[4*g +: 4]));
    end
    always_comb begin
        state_d = state_q;
        sh_d = sh_q;
        scr_d = scr_q;
        cnt_d = cnt_q;
        pend_d = pend_q;
        done_d = 1'b0;
        ovf_d = ovf_q;
        bcd_d = bcd_q;
        if (state_q == IDLE) begin
            if (start) begin
                state_d = SHIFT;
                sh_d = bin;
                scr_d = '0;
                cnt_d = CW'(IN_WIDTH);
                pend_d = 64'(bin) > MAXV;
            end
        end else begin
            scr_d = {adj[BW-2:0], sh_q[IN_WIDTH-1]};
            sh_d = sh_q << 1;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                state_d = IDLE;
                done_d = 1'b1;
                ovf_d = pend_q;
                bcd_d = pend_q ? {DIGITS{ERR_NIBBLE}} : scr_d;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sh_q <= '0;
            scr_q <= '0;
            cnt_q <= '0;
            pend_q <= 1'b0;
            done_q <= 1'b0;
            ovf_q <= 1'b0;
            bcd_q <= '0;
        end else begin
            state_q <= state_d;
            sh_q <= sh_d;
            scr_q <= scr_d;
            cnt_q <= cnt_d;
            pend_q <= pend_d;
            done_q <= done_d;
            ovf_q <= ovf_d;
            bcd_q <= bcd_d;
        end
    end
    assign busy = (state_q == SHIFT);
    assign done = done_q;
    assign overflow = ovf_q;
    assign bcd = bcd_q;
endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// tb_bin_to_bcd_converter: directed and random conversions checked against a decimal-arithmetic model
module tb_bin_to_bcd_converter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [15:0] bin = '0;
    logic start = 1'b0;
    logic busy, done, overflow;
    logic [15:0] bcd;
    int checks = 0;
    int errors = 0;
    logic [15:0] exp_bcd = '0;
    logic exp_ovf = 1'b0;
    bin_to_bcd_converter dut (
        .clk(clk), .reset(reset), .bin(bin), .start(start),
        .busy(busy), .done(done), .overflow(overflow), .bcd(bcd)
    );
    always #5 clk = ~clk;
    function automatic logic [15:0] ref_bcd(input int v);
        if (v > 9999) return 16'hEEEE;
        return {4'(v / 1000), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic convert(input int v);
        bin = 16'(v);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_start", 32'(busy), 1);
        for (int i = 1; i < 16; i++) begin
            tick();
            check("hold_bcd", 32'(bcd), 32'(exp_bcd));
            check("busy_mid", 32'(busy), 1);
            check("done_mid", 32'(done), 0);
        end
        tick();
        exp_bcd = ref_bcd(v);
        exp_ovf = v > 9999;
        check("done_pulse", 32'(done), 1);
        check("busy_end", 32'(busy), 0);
        check("bcd_result", 32'(bcd), 32'(exp_bcd));
        check("ovf_result", 32'(overflow), 32'(exp_ovf));
        tick();
        check("done_clear", 32'(done), 0);
        check("bcd_after", 32'(bcd), 32'(exp_bcd));
        check("ovf_hold", 32'(overflow), 32'(exp_ovf));
    endtask
    initial begin
        int ndone;
        logic d;
        tick();
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_bcd", 32'(bcd), 0);
        reset = 1'b0;
        convert(1234);
        convert(0);
        convert(9999);
        convert(10000);
        convert(65535);
        convert(42);
        // a second start mid-conversion must be dropped, not queued
        bin = 16'd5678;
        start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int i = 1; i <= 18; i++) begin
            if (i == 5) begin
                bin = 16'd1;
                start = 1'b1;
            end else if (i == 6) start = 1'b0;
            tick();
            if (done) ndone++;
            if (i == 16) begin
                check("ign_done", 32'(done), 1);
                check("ign_bcd", 32'(bcd), 32'h5678);
            end
        end
        check("ign_ndone", 32'(ndone), 1);
        check("ign_busy", 32'(busy), 0);
        exp_bcd = 16'h5678;
        bin = 16'd321;
        start = 1'b1;
        for (int i = 0; i < 51; i++) begin
            tick();
            d = (i % 17) == 16;
            check("rep_done", 32'(done), 32'(d));
            check("rep_busy", 32'(busy), 32'(!d));
            if (d) check("rep_bcd", 32'(bcd), 32'h0321);
        end
        start = 1'b0;
        exp_bcd = 16'h0321;
        tick();
        check("rep_idle", 32'(busy), 0);
        bin = 16'd8888;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        reset = 1'b1;
        tick();
        check("abort_busy", 32'(busy), 0);
        check("abort_bcd", 32'(bcd), 0);
        check("abort_done", 32'(done), 0);
        reset = 1'b0;
        exp_bcd = '0;
        tick();
        check("abort_nodone", 32'(done), 0);
        convert(7);
        for (int n = 0; n < 24; n++) convert($urandom % 2 ? int'($urandom_range(0, 9999)) : int'($urandom_range(0, 65535)));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
